axis_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter. It shares one AXI-Stream link (downstream axis_s-style slave) among NUM_SRC axis_m-style masters.
- A grant is held from the first beat until the tlast handshake; packets are never interleaved.
- Sits between the stream masters and the single slave. Owns all sequencing of the shared tvalid/tready/tdata/tlast path.

---
 rtl/axis_rr_arbiter_pkg.sv | 37 +++
 rtl/axis_rr_arbiter_rr_picker.sv | 25 ++
 rtl/axis_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream round-robin arbiter.
package axis_arb_pkg;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned MAX_SRC     = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // First set bit of req searching upward from last+1 with wrap-around over n
    // sources; returns last unchanged when nothing is requesting.
    function automatic logic [3:0] next_rr(
        input logic [MAX_SRC-1:0] req,
        input logic [3:0]         last,
        input int unsigned        n
    );
        logic [3:0] pick;
        logic [3:0] k;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_SRC; i++) begin
            if (i <= n) begin
                k = 4'((32'(last) + i) % n);
                if (!found && req[k]) begin
                    pick  = k;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: request vector plus last winner
// gives the next winner in round-robin order.
import axis_arb_pkg::*;

module rr_picker #(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last,
    output logic                       valid,
    output logic [$clog2(NUM_SRC)-1:0] idx
);

    localparam int unsigned IW = $clog2(NUM_SRC);

    logic [MAX_SRC-1:0] req_ext;

    // rotate-priority search starting just after the previous winner
    always_comb begin
        req_ext = MAX_SRC'(req);
        valid   = |req;
        idx     = IW'(next_rr(req_ext, 4'(last), NUM_SRC));
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream link among
// NUM_SRC masters. A grant is held from the first beat to the tlast handshake.
// Optional macro AXIS_ARB_MAXLEN_EN: per-packet beat limit MAX_BEATS with
// forced tlast and a sticky len_err flag.
import axis_arb_pkg::*;

module axis_rr_arbiter #(
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BEATS = 64
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [NUM_SRC-1:0]         s_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0]  s_tdata,
    input  logic [NUM_SRC-1:0]         s_tlast,
    output logic [NUM_SRC-1:0]         s_tready,
    output logic                       m_tvalid,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       len_err
);

    localparam int unsigned   GW       = $clog2(NUM_SRC);
    localparam logic [GW-1:0] LAST_SRC = GW'(NUM_SRC - 1);

    if (NUM_SRC < 2 || NUM_SRC > MAX_SRC || MAX_BEATS < 2) begin : g_bad_cfg
        $error("axis_rr_arbiter: parameter out of range");
    end

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick_idx;
    logic          pick_valid;
    logic          xfer;
    logic          beat_done;
    logic          end_of_pkt;
    logic          force_last;

    rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req   (s_tvalid),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign xfer = (state == XFER);
    assign busy = xfer;

    // pass the granted source straight through; everything idles low otherwise
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        if (xfer) begin
            s_tready[grant_id] = m_tready;
            m_tvalid           = s_tvalid[grant_id];
            m_tdata            = s_tdata[grant_id*DATA_W +: DATA_W];
            m_tlast            = s_tlast[grant_id] | force_last;
        end
        beat_done  = m_tvalid && m_tready;
        end_of_pkt = beat_done && m_tlast;
    end

`ifdef AXIS_ARB_MAXLEN_EN
    localparam int unsigned   CW        = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_BEATS - 1);

    logic [CW-1:0] beat_cnt;
    logic          len_err_q;

    assign force_last = xfer && (beat_cnt == CNT_LIMIT) && !s_tlast[grant_id];
    assign len_err    = len_err_q;

    // count beats of the open packet; latch any forced release as an error
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (!xfer) begin
                beat_cnt <= '0;
            end else if (beat_done) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (beat_done && force_last) begin
                len_err_q <= 1'b1;
            end
        end
    end
`else
    assign force_last = 1'b0;
    assign len_err    = 1'b0;
`endif

    // grant on any request from IDLE, release after the tlast handshake
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_SRC;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (end_of_pkt) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: queue-fed stream masters, a
// packet-level reference model compared every cycle, plus directed literals.
module tb_axis_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;
`ifdef AXIS_ARB_MAXLEN_EN
    localparam bit MAXLEN = 1'b1;
`else
    localparam bit MAXLEN = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            m_tready = 1'b1;
    logic [1:0]      grant_id;
    logic            busy;
    logic            len_err;

    axis_rr_arbiter #(
        .NUM_SRC   (N),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant_id (grant_id),
        .busy     (busy),
        .len_err  (len_err)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
        logic        l;
        int          src;
    } beat_t;

    logic [32:0] srcq [N][$];
    logic [N-1:0] hs = '0;
    bit    tog_mode  = 1'b0;
    bit    all_valid = 1'b0;
    beat_t rec[$];
    int    grants[$];
    logic  busy_d = 1'b0;

    // reference model: owner of the link (-1 = idle), last winner, beat count
    int own, mgid, mlast, mcnt;
    bit mlerr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        own   = -1;
        mgid  = 0;
        mlast = N - 1;
        mcnt  = 0;
        mlerr = 1'b0;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // per-cycle compare against the model, then advance the model
    always @(negedge aclk) begin
        logic [31:0] e_d;
        logic        e_v, e_l, frc, found;
        logic [3:0]  e_rdy;
        int          k;
        if (!areset_n) model_reset();
        if (own >= 0) begin
            frc   = MAXLEN && (mcnt == MAXB - 1) && !s_tlast[own];
            e_v   = s_tvalid[own];
            e_d   = s_tdata[own*DW +: DW];
            e_l   = s_tlast[own] | frc;
            e_rdy = 4'(m_tready) << own;
        end else begin
            frc = 1'b0; e_v = 1'b0; e_d = '0; e_l = 1'b0; e_rdy = '0;
        end
        chk("cycle {tvalid,tlast,s_tready,busy,len_err,grant_id,tdata}",
            {m_tvalid, m_tlast, s_tready, busy, len_err, grant_id, m_tdata},
            {e_v, e_l, e_rdy, own >= 0, mlerr, 2'(mgid), e_d});
        if (m_tvalid && m_tready) rec.push_back('{cyc, m_tdata, m_tlast, int'(grant_id)});
        if (busy && !busy_d) grants.push_back(int'(grant_id));
        busy_d = busy;
        hs = s_tvalid & s_tready;
        if (areset_n) begin
            if (own < 0) begin
                found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    k = (mlast + j) % N;
                    if (!found && s_tvalid[k]) begin
                        found = 1'b1; own = k; mgid = k; mcnt = 0;
                    end
                end
            end else if (s_tvalid[own] && m_tready) begin
                mcnt++;
                if (e_l) begin
                    if (frc) mlerr = 1'b1;
                    mlast = own;
                    own   = -1;
                end
            end
        end
        cyc++;
    end

    // stream masters: pop on handshake, present queue heads
    always @(posedge aclk) begin
        for (int i = 0; i < N; i++)
            if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        #2;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]         = all_valid || (srcq[i].size() > 0);
            s_tdata[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0][31:0] : '0;
            s_tlast[i]          = (srcq[i].size() > 0) ? srcq[i][0][32] : 1'b0;
        end
        if (tog_mode) m_tready = ~m_tready;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input int src, input int n, input logic [31:0] base,
                        input logic [31:0] step, input bit withlast);
        for (int b = 0; b < n; b++)
            srcq[src].push_back({withlast && (b == n - 1), base + step * 32'(b)});
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((pending() || busy) && c < maxc) begin
            tick();
            c++;
        end
        chk("drain_timeout", {63'b0, pending() || busy}, 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, st, c, g0;
        model_reset();

        // reset with every source requesting
        all_valid = 1'b1;
        repeat (4) tick();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        all_valid = 1'b0;
        areset_n  = 1'b1;
        tick();

        // single source, 3 beats
        base = rec.size(); st = cyc; g0 = grants.size();
        push(1, 3, 32'haaaa_bbbb, 32'h0, 1'b1);
        drain(20);
        chk("single_nbeats", rec.size() - base, 3);
        chk("single_grant", (grants.size() > g0) ? grants[g0] : -1, 1);
        for (int b = 0; b < 3; b++) begin
            if (rec.size() >= base + 3) begin
                chk("single_data", rec[base+b].d, 32'haaaa_bbbb);
                chk("single_last", rec[base+b].l, (b == 2) ? 1 : 0);
                chk("single_cycle_offset", rec[base+b].c - st, b + 1);
            end
        end

        // contention from a fresh reset: rotation 0,1,2,3,0
        areset_n = 1'b0;
        repeat (2) tick();
        areset_n = 1'b1;
        base = rec.size(); g0 = grants.size();
        for (int p = 0; p < 5; p++)
            push(p % 4, 2, {8'(p % 4), 8'(p / 4), 16'h0}, 32'h1, 1'b1);
        drain(60);
        chk("cont_nbeats", rec.size() - base, 10);
        chk("cont_ngrants", grants.size() - g0, 5);
        if (rec.size() >= base + 10 && grants.size() >= g0 + 5) begin
            for (int p = 0; p < 5; p++) begin
                chk("cont_grant_order", grants[g0+p], p % 4);
                chk("cont_pkt_spacing", rec[base+2*p].c - rec[base].c, 3 * p);
                for (int b = 0; b < 2; b++)
                    chk("cont_data_order", rec[base+2*p+b].d, {8'(p % 4), 8'(p / 4), 16'(b)});
            end
        end

        // backpressure: src2 wins over src0 (last grant was 0), tready toggles
        base = rec.size(); g0 = grants.size();
        tog_mode = 1'b1;
        push(2, 3, 32'h2200_0000, 32'h1, 1'b1);
        push(0, 2, 32'h0000_0c00, 32'h1, 1'b1);
        drain(60);
        tog_mode = 1'b0;
        m_tready = 1'b1;
        chk("bp_nbeats", rec.size() - base, 5);
        if (rec.size() >= base + 5 && grants.size() >= g0 + 2) begin
            chk("bp_first_grant", grants[g0], 2);
            chk("bp_second_grant", grants[g0+1], 0);
            for (int b = 0; b < 3; b++) chk("bp_src2_data", rec[base+b].d, 32'h2200_0000 + 32'(b));
            chk("bp_beat_gap1", rec[base+1].c - rec[base].c, 2);
            chk("bp_beat_gap2", rec[base+2].c - rec[base+1].c, 2);
            chk("bp_src0_after", rec[base+3].d, 32'h0000_0c00);
        end
        tick();

        // reset after beat 2 of a 5-beat packet
        base = rec.size(); g0 = grants.size();
        push(3, 5, 32'h3300_0000, 32'h1, 1'b1);
        c = 0;
        while (rec.size() < base + 2 && c < 30) begin
            tick();
            c++;
        end
        chk("midrst_reached_beat2", rec.size() - base, 2);
        areset_n = 1'b0;
        srcq[3].delete();
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) tick();
        areset_n = 1'b1;
        g0 = grants.size();
        push(1, 2, 32'h0101_0000, 32'h1, 1'b1);
        push(0, 2, 32'h0000_0101, 32'h1, 1'b1);
        drain(40);
        if (grants.size() >= g0 + 2) begin
            chk("midrst_first_winner", grants[g0], 0);
            chk("midrst_second_winner", grants[g0+1], 1);
        end else begin
            chk("midrst_ngrants", grants.size() - g0, 2);
        end

        // overlength packet from src3: six beats, no tlast
        base = rec.size(); g0 = grants.size();
        push(3, 6, 32'h5500_0000, 32'h1, 1'b0);
        c = 0;
        while (pending() && c < 40) begin
            tick();
            c++;
        end
        chk("maxlen_drain_timeout", {63'b0, pending()}, 64'd0);
        repeat (3) tick();
        chk("maxlen_nbeats", rec.size() - base, 6);
        if (rec.size() >= base + 6) begin
            for (int b = 0; b < 6; b++) begin
                chk("maxlen_data", rec[base+b].d, 32'h5500_0000 + 32'(b));
                chk("maxlen_last", rec[base+b].l, (MAXLEN && b == 3) ? 1 : 0);
            end
            chk("maxlen_gap_after_beat4", rec[base+4].c - rec[base+3].c, MAXLEN ? 2 : 1);
        end
        chk("maxlen_len_err", len_err, MAXLEN ? 1 : 0);
        chk("maxlen_grants", grants.size() - g0, MAXLEN ? 2 : 1);
        repeat (2) tick();
        chk("maxlen_len_err_sticky", len_err, MAXLEN ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
